// File: rtl/pipe_chain_if.sv
// pipe_chain_if: upstream and downstream valid/ready/data bundle for pipe_chain.
// The chain itself connects through the slave modport; the producer/consumer
// side (or a bench) drives through the master modport.
interface pipe_chain_if #(
  parameter int WIDTH = 18
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: elastic register chain of DEPTH stages with per-stage valid bits,
// valid/ready backpressure, bubble collapsing and synchronous flush.
// DEPTH=0 is a pure combinational bypass.
// Optional feature macro: PIPE_CHAIN_STALL_CNT_EN adds the stall_cnt port, a
// saturating 16-bit count of cycles where the output word waits on out_ready.
module pipe_chain #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 2,
  localparam int CW    = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  pipe_chain_if.slave   bus,
  output logic [CW-1:0] occupancy
`ifdef PIPE_CHAIN_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  // Number of set bits in an 8-bit vector; DEPTH never exceeds 8.
  function automatic logic [3:0] popcount8(input logic [7:0] vec);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, vec[i]};
    end
    return sum;
  endfunction

  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;
  logic [CW-1:0]    occupancy_s;

  generate
    if (DEPTH == 0) begin : g_bypass
      // No storage: the chain is a wire and flush has nothing to clear.
      logic unused_s;
      assign unused_s    = ^{clk, rst, flush};
      assign in_ready_s  = bus.out_ready;
      assign out_valid_s = bus.in_valid;
      assign out_data_s  = bus.in_data;
      assign occupancy_s = {CW{1'b0}};
    end else begin : g_chain
      logic [DEPTH-1:0] v_r;
      logic [WIDTH-1:0] d_r [DEPTH];
      logic [DEPTH-1:0] en_s;
      logic [DEPTH-1:0] up_v_s;
      logic [WIDTH-1:0] up_d_s [DEPTH];
      logic [7:0]       v_pad_s;

      // Advance enables: a stage may load if it or any stage ahead of it is
      // empty, or the consumer takes the last word this cycle.
      always_comb begin
        logic acc;
        acc  = bus.out_ready;
        en_s = {DEPTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
          acc     = acc | ~v_r[i];
          en_s[i] = acc;
        end
      end

      // Upstream view of each stage: the input port for stage 0, the
      // previous stage otherwise.
      always_comb begin
        up_v_s[0] = bus.in_valid;
        up_d_s[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
          up_v_s[i] = v_r[i-1];
          up_d_s[i] = d_r[i-1];
        end
      end

      // Stage registers: reset clears everything, flush clears only the valid
      // bits, otherwise enabled stages take their upstream word.
      always_ff @(posedge clk) begin
        if (!rst) begin
          v_r <= {DEPTH{1'b0}};
          for (int i = 0; i < DEPTH; i++) begin
            d_r[i] <= {WIDTH{1'b0}};
          end
        end else if (flush) begin
          v_r <= {DEPTH{1'b0}};
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (en_s[i]) begin
              v_r[i] <= up_v_s[i];
              if (up_v_s[i]) begin
                d_r[i] <= up_d_s[i];
              end
            end
          end
        end
      end

      // Widen the valid vector to the fixed popcount input.
      always_comb begin
        v_pad_s            = 8'h00;
        v_pad_s[DEPTH-1:0] = v_r;
      end

      assign in_ready_s  = en_s[0] & ~flush;
      assign out_valid_s = v_r[DEPTH-1];
      assign out_data_s  = d_r[DEPTH-1];
      assign occupancy_s = CW'(popcount8(v_pad_s));
    end
  endgenerate

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign occupancy     = occupancy_s;

`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Count cycles where a valid output word is held back; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (flush) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_s && !bus.out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: drives DEPTH=2, DEPTH=4 and DEPTH=0 chains side by side and
// checks them against a timestamp queue model of the elastic pipeline.
module tb_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv   [3];
  logic [17:0] id   [3];
  logic        ordy [3];
  logic        fl   [3];
  logic        ir_o [3];
  logic        ov_o [3];
  logic [17:0] od_o [3];
  logic [3:0]  occ_o [3];
  logic [1:0]  occ2;
  logic [2:0]  occ4;
  logic [0:0]  occ0;

  pipe_chain_if #(.WIDTH(18)) b2 ();
  pipe_chain_if #(.WIDTH(18)) b4 ();
  pipe_chain_if #(.WIDTH(18)) b0 ();

  assign b2.in_valid = iv[0];  assign b2.in_data = id[0];  assign b2.out_ready = ordy[0];
  assign b4.in_valid = iv[1];  assign b4.in_data = id[1];  assign b4.out_ready = ordy[1];
  assign b0.in_valid = iv[2];  assign b0.in_data = id[2];  assign b0.out_ready = ordy[2];
  assign ir_o[0] = b2.in_ready;  assign ov_o[0] = b2.out_valid;  assign od_o[0] = b2.out_data;
  assign ir_o[1] = b4.in_ready;  assign ov_o[1] = b4.out_valid;  assign od_o[1] = b4.out_data;
  assign ir_o[2] = b0.in_ready;  assign ov_o[2] = b0.out_valid;  assign od_o[2] = b0.out_data;
  assign occ_o[0] = {2'b00, occ2};
  assign occ_o[1] = {1'b0, occ4};
  assign occ_o[2] = {3'b000, occ0};

`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [15:0] st2, st4, st0;
  logic [15:0] st_o [3];
  assign st_o[0] = st2;
  assign st_o[1] = st4;
  assign st_o[2] = st0;
`endif

  pipe_chain #(.WIDTH(18), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(fl[0]), .bus(b2), .occupancy(occ2)
`ifdef PIPE_CHAIN_STALL_CNT_EN
    , .stall_cnt(st2)
`endif
  );

  pipe_chain #(.WIDTH(18), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(fl[1]), .bus(b4), .occupancy(occ4)
`ifdef PIPE_CHAIN_STALL_CNT_EN
    , .stall_cnt(st4)
`endif
  );

  pipe_chain #(.WIDTH(18), .DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .flush(fl[2]), .bus(b0), .occupancy(occ0)
`ifdef PIPE_CHAIN_STALL_CNT_EN
    , .stall_cnt(st0)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: words in flight per chain, each with the cycle it was accepted.
  // A word shows at the output at max(accept + DEPTH, previous take + 1).
  int          m_cnt  [2];
  int          m_head [2];
  int          m_last [2];
  logic [17:0] m_d [2][8];
  int          m_t [2][8];
  logic [15:0] m_st [3];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic exp_ov(input int k);
    int due;
    if (m_cnt[k] == 0) return 1'b0;
    due = m_t[k][m_head[k]] + dep(k);
    if (m_last[k] + 1 > due) due = m_last[k] + 1;
    return (cyc >= due);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_head[k] = 0;
      m_last[k] = -100;
    end
    for (int k = 0; k < 3; k++) m_st[k] = 16'h0000;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: check all chains against the model, clock, update model.
  task automatic step();
    logic ove [3];
    logic ire [3];
    #1;
    for (int k = 0; k < 2; k++) begin
      ove[k] = exp_ov(k);
      ire[k] = !fl[k] && ((m_cnt[k] < dep(k)) || ordy[k]);
      chk($sformatf("in_ready_d%0d", dep(k)), 64'(ir_o[k]), 64'(ire[k]));
      chk($sformatf("out_valid_d%0d", dep(k)), 64'(ov_o[k]), 64'(ove[k]));
      chk($sformatf("occupancy_d%0d", dep(k)), 64'(occ_o[k]), 64'(m_cnt[k]));
      if (ove[k]) chk($sformatf("out_data_d%0d", dep(k)), 64'(od_o[k]), 64'(m_d[k][m_head[k]]));
    end
    ove[2] = iv[2];
    ire[2] = ordy[2];
    chk("bypass_valid", 64'(ov_o[2]), 64'(iv[2]));
    chk("bypass_data", 64'(od_o[2]), 64'(id[2]));
    chk("bypass_ready", 64'(ir_o[2]), 64'(ordy[2]));
    chk("bypass_occ", 64'(occ_o[2]), 64'd0);
`ifdef PIPE_CHAIN_STALL_CNT_EN
    for (int k = 0; k < 3; k++) chk($sformatf("stall_cnt_%0d", k), 64'(st_o[k]), 64'(m_st[k]));
`endif
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ove[k] && ordy[k]) begin
          m_head[k] = (m_head[k] + 1) % 8;
          m_cnt[k]  = m_cnt[k] - 1;
          m_last[k] = cyc;
        end
        if (fl[k]) begin
          m_cnt[k] = 0;
        end else if (iv[k] && ire[k]) begin
          m_d[k][(m_head[k] + m_cnt[k]) % 8] = id[k];
          m_t[k][(m_head[k] + m_cnt[k]) % 8] = cyc;
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (fl[k]) m_st[k] = 16'h0000;
        else if (ove[k] && !ordy[k] && m_st[k] != 16'hFFFF) m_st[k] = m_st[k] + 16'h0001;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic [17:0] id;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [17:0] od;
    logic [3:0]  occ;
  } vec_t;

  vec_t        tbl [7];
  int          first_acc, first_ov, nrx;
  logic [17:0] rx [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Fill with A,B under backpressure on DEPTH=2, then drain.
    tbl[0] = '{1'b1, 18'h0000A, 1'b0, 1'b1, 1'b0, 18'h00000, 4'd0};
    tbl[1] = '{1'b1, 18'h0000B, 1'b0, 1'b1, 1'b0, 18'h00000, 4'd1};
    tbl[2] = '{1'b1, 18'h0000C, 1'b0, 1'b0, 1'b1, 18'h0000A, 4'd2};
    tbl[3] = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 18'h0000A, 4'd2};
    tbl[4] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h0000A, 4'd2};
    tbl[5] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h0000B, 4'd1};
    tbl[6] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h0000B, 4'd0};

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = 18'h00000; ordy[k] = 1'b0; fl[k] = 1'b0;
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state.
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_out_valid_%0d", k), 64'(ov_o[k]), 64'd0);
      chk($sformatf("reset_out_data_%0d", k), 64'(od_o[k]), 64'd0);
      chk($sformatf("reset_occupancy_%0d", k), 64'(occ_o[k]), 64'd0);
      chk($sformatf("reset_in_ready_%0d", k), 64'(ir_o[k]), 64'd1);
    end
`ifdef PIPE_CHAIN_STALL_CNT_EN
    chk("reset_stall_cnt", 64'(st2), 64'd0);
`endif
    step();
    rst = 1'b1;

    // Table-driven fill/drain on DEPTH=2.
    for (int i = 0; i < 7; i++) begin
      iv[0] = tbl[i].iv; id[0] = tbl[i].id; ordy[0] = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(ir_o[0]), 64'(tbl[i].ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(ov_o[0]), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_out_data", i), 64'(od_o[0]), 64'(tbl[i].od));
      chk($sformatf("tbl%0d_occupancy", i), 64'(occ_o[0]), 64'(tbl[i].occ));
      step();
    end

    // Stream 1..16 through DEPTH=2 at full rate.
    first_acc = -1; first_ov = -1; nrx = 0;
    for (int c = 0; c < 20; c++) begin
      iv[0] = (c < 16); id[0] = 18'(c + 1); ordy[0] = 1'b1;
      #1;
      if (iv[0] && ir_o[0] && first_acc < 0) first_acc = cyc;
      if (ov_o[0] && first_ov < 0) first_ov = cyc;
      if (ov_o[0] && nrx < 16) begin rx[nrx] = od_o[0]; nrx++; end
      if (c >= 2 && c < 16) chk("stream_occupancy", 64'(occ_o[0]), 64'd2);
      step();
    end
    chk("stream_latency", 64'(first_ov - first_acc), 64'd2);
    chk("stream_count", 64'(nrx), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("stream_word%0d", i), 64'(rx[i]), 64'(i + 1));
    iv[0] = 1'b0;

    // Bubble collapse on DEPTH=4: one word, consumer stalled.
    iv[1] = 1'b1; id[1] = 18'h00003; ordy[1] = 1'b0;
    step();
    iv[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 3) chk("bubble_not_yet", 64'(ov_o[1]), 64'd0);
      if (c == 4) begin
        chk("bubble_out_valid", 64'(ov_o[1]), 64'd1);
        chk("bubble_out_data", 64'(od_o[1]), 64'h3);
        chk("bubble_in_ready", 64'(ir_o[1]), 64'd1);
        chk("bubble_occupancy", 64'(occ_o[1]), 64'd1);
      end
      step();
    end

    // Flush DEPTH=4 at occupancy 3 with a word offered.
    iv[1] = 1'b1; id[1] = 18'h00005; step();
    iv[1] = 1'b1; id[1] = 18'h00006; step();
    iv[1] = 1'b1; id[1] = 18'h00007; fl[1] = 1'b1;
    #1;
    chk("flush_in_ready", 64'(ir_o[1]), 64'd0);
    chk("flush_occ_before", 64'(occ_o[1]), 64'd3);
    step();
    fl[1] = 1'b0; iv[1] = 1'b0;
    #1;
    chk("flush_occ_after", 64'(occ_o[1]), 64'd0);
    chk("flush_out_valid", 64'(ov_o[1]), 64'd0);
`ifdef PIPE_CHAIN_STALL_CNT_EN
    chk("flush_stall_cnt", 64'(st4), 64'd0);
`endif
    step();
    #1;
    chk("flush_word_dropped", 64'(occ_o[1]), 64'd0);
    step();

    // Reset mid-stream on DEPTH=2 after 5 stall cycles.
    ordy[0] = 1'b0; fl[0] = 1'b1; step();
    fl[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 18'h00011; step();
    iv[0] = 1'b1; id[0] = 18'h00012; step();
    iv[0] = 1'b0;
    repeat (5) step();
    #1;
    chk("midrst_occ_before", 64'(occ_o[0]), 64'd2);
`ifdef PIPE_CHAIN_STALL_CNT_EN
    chk("midrst_stall_5", 64'(st2), 64'd5);
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(ov_o[0]), 64'd0);
    chk("midrst_out_data", 64'(od_o[0]), 64'd0);
    chk("midrst_occupancy", 64'(occ_o[0]), 64'd0);
`ifdef PIPE_CHAIN_STALL_CNT_EN
    chk("midrst_stall_0", 64'(st2), 64'd0);
`endif
    step();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k] = ($urandom_range(0, 3) != 0);
        id[k] = 18'($urandom);
        if ((c % 200) < 100) ordy[k] = ($urandom_range(0, 3) != 0);
        else ordy[k] = ($urandom_range(0, 3) == 0);
        fl[k] = (k < 2) ? ($urandom_range(0, 31) == 0) : 1'b0;
      end
      rst = ($urandom_range(0, 127) != 0);
      step();
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) fl[k] = 1'b0;

    // DEPTH=0 bypass.
    iv[2] = 1'b1; id[2] = 18'h2AAAA; ordy[2] = 1'b1;
    #1;
    chk("d0_data", 64'(od_o[2]), 64'h2AAAA);
    chk("d0_ready_hi", 64'(ir_o[2]), 64'd1);
    ordy[2] = 1'b0; id[2] = 18'h15555;
    #1;
    chk("d0_ready_lo", 64'(ir_o[2]), 64'd0);
    chk("d0_valid", 64'(ov_o[2]), 64'd1);
    chk("d0_data2", 64'(od_o[2]), 64'h15555);
    step();
`ifdef PIPE_CHAIN_STALL_CNT_EN
    repeat (70000) @(posedge clk);
    @(negedge clk);
    #1;
    chk("d0_stall_saturate", 64'(st0), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised elastic pipeline register chain. It generalises the single enabled register into DEPTH stages with per-stage valid tracking, valid/ready backpressure, bubble collapsing and synchronous flush. It sits on the DSP operand and result paths, replacing fixed A/B/M/P register stages. DEPTH=0 gives the combinational-bypass mode.

## Interface
- WIDTH, 18: data width in bits (1..64).
- DEPTH, 2: number of register stages (0..8); 0 = pure bypass.
- CW, $clog2(DEPTH+1) (minimum 1): width of the occupancy output. This is a localparam and cannot be overridden.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  last-stage data.
- occupancy  out  CW  number of valid stages.
- stall_cnt  out  16  output stall counter; present only with PIPE_CHAIN_STALL_CNT_EN.

## Operation
- Stages are indexed 0 (input side) to DEPTH-1 (output). Each stage i holds a valid bit v[i] and data d[i].
- Stage advance enable is en[i] = !v[i] | en[i+1], with en[DEPTH] = out_ready. Bubbles therefore collapse: an empty stage always loads, even when downstream is stalled.
- When en[i] is high:
  - v[i] takes the upstream valid (in_valid for stage 0, v[i-1] otherwise).
  - d[i] loads the upstream data only if the upstream valid is 1. Otherwise d[i] holds.
- When en[i] is low, the stage holds v[i] and d[i].
- Outputs and status:
  - in_ready = en[0] & !flush.
  - out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
  - occupancy = popcount(v), combinational from the registers.
- Transfer rules:
  - An input transfer occurs on in_valid & in_ready.
  - An output transfer occurs on out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Flush (flush=1 at a posedge):
  - All v[i] become 0; d[i] holds.
  - in_valid is ignored that cycle and no input is accepted.
  - out_valid and out_ready behave normally in the flush cycle, so a word presented with out_ready=1 is still consumed.
- Reset (rst=0 at a posedge):
  - All v[i] become 0 and all d[i] become 0. Reset has priority over flush and data movement.
  - Reset asserted mid-stream discards all in-flight words. There is no partial drain.
- DEPTH=0:
  - out_valid = in_valid, out_data = in_data, in_ready = out_ready.
  - occupancy = 0. flush is ignored. No registers exist.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0. in_ready=1 after reset, because all stages are empty and flush=0.
- Latency: a word accepted at cycle N appears on out_valid/out_data at cycle N+DEPTH if no stall occurs.
- Throughput: one word per cycle with out_ready held at 1.
- in_ready depends combinationally on out_ready through the en chain. The path is at most DEPTH gates deep, and this is intentional.
- Full condition: occupancy=DEPTH and out_ready=0 gives in_ready=0. With occupancy=DEPTH and out_ready=1, in and out transfer in the same cycle and occupancy stays DEPTH.
- Simultaneous flush and output transfer: the word is consumed and occupancy is 0 next cycle.
- Simultaneous flush and rst=0: reset applies.

## Configuration
- PIPE_CHAIN_STALL_CNT_EN defined:
  - stall_cnt is a 16-bit register that increments on every cycle with out_valid=1 and out_ready=0.
  - It saturates at 16'hFFFF and does not wrap.
  - It is cleared by reset and by flush. It is not cleared by a successful transfer.
- PIPE_CHAIN_STALL_CNT_EN undefined: the stall_cnt port and its logic are absent.

## Test plan
- Reset, then stream 0x00001..0x00010 with in_valid=1 and out_ready=1 (WIDTH=18, DEPTH=2) -> first out_valid 2 cycles after first accept, all 16 words in order, occupancy=2 in steady state.
- Fill with out_ready=0 and words 0xA, 0xB -> occupancy=2, in_ready=0, out_data holds 0xA. Raise out_ready -> 0xA then 0xB delivered on consecutive cycles.
- Bubble collapse (DEPTH=4): a single word 0x3, then in_valid=0, out_ready=0 -> the word reaches stage 3 after 4 cycles, in_ready stays 1, occupancy=1.
- Flush with occupancy=3 (DEPTH=4) and in_valid=1 -> next cycle occupancy=0 and out_valid=0, and the input word is not accepted. Stall counter (macro on) reads 0.
- Reset mid-stream with rst=0 for one cycle at occupancy=2 -> out_valid=0, out_data=0, occupancy=0 next cycle. Stall counter (macro on): 5 stall cycles then reset give 5, then 0.
- DEPTH=0 -> out_data equals in_data in the same cycle, and in_ready follows out_ready; with macro on, 70000 stall cycles give stall_cnt=16'hFFFF.
